// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants, line/frame
// length helpers and the coordinate type used across the pixel path.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  // Pixel-clock phase: reads go out on PH_READ, pins update on PH_OUT.
  typedef enum logic {
    PH_READ = 1'b0,
    PH_OUT  = 1'b1
  } phase_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Frame buffer read port: the scanout drives address and strobe, the frame
// buffer answers with one 4-bit pixel a clock later.
interface vga_scanout_if;
  import vga_timing_pkg::*;

  coord_t      rd_x;
  coord_t      rd_y;
  logic        rd_en;
  logic [3:0]  rd_data;

  modport master (output rd_x, output rd_y, output rd_en, input rd_data);
  modport slave  (input rd_x, input rd_y, input rd_en, output rd_data);

endinterface

// File: rtl/vga_sync_counter.sv
// Pixel-phase divider plus horizontal/vertical scan counters, with the
// active-region, sync and blanking decode taken straight off the counters.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic   clk,
  input  logic   reset,
  output phase_e ph_o,
  output coord_t h_cnt_o,
  output coord_t v_cnt_o,
  output logic   active_o,
  output logic   hs_n_o,
  output logic   vs_n_o,
  output logic   vblank_o,
  output logic   origin_o
);

  localparam coord_t H_LAST       = coord_t'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
  localparam coord_t V_LAST       = coord_t'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
  localparam coord_t H_ACT        = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT        = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t V_SYNC_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  phase_e ph_q, ph_d;
  coord_t h_cnt_q, h_cnt_d;
  coord_t v_cnt_q, v_cnt_d;

  // Next-state: phase toggles every clk; counters step only at the end of the output phase.
  always_comb begin
    ph_d    = (ph_q == PH_READ) ? PH_OUT : PH_READ;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (ph_q == PH_OUT) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // Phase and scan position registers; reset restarts the scan at (0,0) in the read phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q    <= PH_READ;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      ph_q    <= ph_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign ph_o     = ph_q;
  assign h_cnt_o  = h_cnt_q;
  assign v_cnt_o  = v_cnt_q;
  assign active_o = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_n_o   = !((h_cnt_q >= H_SYNC_FIRST) && (h_cnt_q <= H_SYNC_LAST));
  assign vs_n_o   = !((v_cnt_q >= V_SYNC_FIRST) && (v_cnt_q <= V_SYNC_LAST));
  assign vblank_o = (v_cnt_q >= V_ACT);
  assign origin_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// Display-side frame buffer reader: issues one read per visible pixel in the
// read phase and registers colour, syncs and frame markers in the output phase.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  vga_scanout_if.master fb,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vblank,
  output logic          frame_start
);

  phase_e ph;
  coord_t h_cnt;
  coord_t v_cnt;
  logic   active;
  logic   hs_n;
  logic   vs_n;
  logic   vblank_now;
  logic   origin;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .ph_o     (ph),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .active_o (active),
    .hs_n_o   (hs_n),
    .vs_n_o   (vs_n),
    .vblank_o (vblank_now),
    .origin_o (origin)
  );

  logic       rd_en_q, rd_en_d;
  coord_t     rd_x_q, rd_x_d;
  coord_t     rd_y_q, rd_y_d;
  logic [3:0] colour_q, colour_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       vblank_q, vblank_d;
  logic       frame_start_q, frame_start_d;

  // Read phase launches the fetch; output phase captures the returned pixel
  // together with the syncs so every pin moves on the same edge.
  always_comb begin
    rd_en_d       = rd_en_q;
    rd_x_d        = rd_x_q;
    rd_y_d        = rd_y_q;
    colour_d      = colour_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    vblank_d      = vblank_q;
    frame_start_d = frame_start_q;
    if (ph == PH_READ) begin
      rd_en_d       = active;
      frame_start_d = 1'b0;
      if (active) begin
        rd_x_d = h_cnt;
        rd_y_d = v_cnt;
      end
    end else begin
      rd_en_d       = 1'b0;
      colour_d      = active ? fb.rd_data : 4'h0;
      hs_d          = hs_n;
      vs_d          = vs_n;
      vblank_d      = vblank_now;
      frame_start_d = origin;
    end
  end

  // Read-port and pin registers; reset parks the pins idle with syncs deasserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q       <= 1'b0;
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      colour_q      <= 4'h0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      rd_en_q       <= rd_en_d;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
      colour_q      <= colour_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb.rd_en    = rd_en_q;
  assign fb.rd_x     = rd_x_q;
  assign fb.rd_y     = rd_y_q;
  assign vga_r       = colour_q;
  assign vga_g       = colour_q;
  assign vga_b       = colour_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout: one instance at full 640x480 timing for
// line-level behaviour, one with a tiny raster so whole frames fit in a short run.
module tb_vga_scanout;

  logic clk;
  logic resetA;
  logic resetB;

  vga_scanout_if fbA ();
  vga_scanout_if fbB ();

  logic [3:0] rA, gA, bA, rB, gB, bB;
  logic       hsA, vsA, vblankA, fsA;
  logic       hsB, vsB, vblankB, fsB;

  int nChecks;
  int nFail;
  int cyc;

  vga_scanout dutA (
    .clk         (clk),
    .reset       (resetA),
    .fb          (fbA),
    .vga_r       (rA),
    .vga_g       (gA),
    .vga_b       (bA),
    .vga_hs      (hsA),
    .vga_vs      (vsA),
    .vblank      (vblankA),
    .frame_start (fsA)
  );

  // Small raster: 16 clocks of pixels per line (8 visible), 8 lines (4 visible).
  vga_scanout #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dutB (
    .clk         (clk),
    .reset       (resetB),
    .fb          (fbB),
    .vga_r       (rB),
    .vga_g       (gB),
    .vga_b       (bB),
    .vga_hs      (hsB),
    .vga_vs      (vsB),
    .vblank      (vblankB),
    .frame_start (fsB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame buffer models: pixel value is the low nibble of the column, valid in
  // the clk after the strobe; every other cycle carries garbage 0xF.
  always @(negedge clk) begin
    fbA.rd_data = fbA.rd_en ? fbA.rd_x[3:0] : 4'hF;
    fbB.rd_data = fbB.rd_en ? fbB.rd_x[3:0] : 4'hF;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstA, input logic rstB);
    resetA = rstA;
    resetB = rstB;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tick();
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, " rd_en"}, fbA.rd_en, 0);
    checkOutput({tag, " rd_x"}, fbA.rd_x, 0);
    checkOutput({tag, " rd_y"}, fbA.rd_y, 0);
    checkOutput({tag, " r"}, rA, 0);
    checkOutput({tag, " g"}, gA, 0);
    checkOutput({tag, " b"}, bA, 0);
    checkOutput({tag, " hs"}, hsA, 1);
    checkOutput({tag, " vs"}, vsA, 1);
    checkOutput({tag, " vblank"}, vblankA, 0);
    checkOutput({tag, " frame_start"}, fsA, 0);
  endtask

  task automatic checkResetB(input string tag);
    checkOutput({tag, " rd_en"}, fbB.rd_en, 0);
    checkOutput({tag, " rd_x"}, fbB.rd_x, 0);
    checkOutput({tag, " rd_y"}, fbB.rd_y, 0);
    checkOutput({tag, " r"}, rB, 0);
    checkOutput({tag, " hs"}, hsB, 1);
    checkOutput({tag, " vs"}, vsB, 1);
    checkOutput({tag, " vblank"}, vblankB, 0);
    checkOutput({tag, " frame_start"}, fsB, 0);
  endtask

  initial begin
    int hsLow, hsFirst, rdCount, grayBad;
    logic [3:0] col1277, col1281;
    int fsCount, fsFirst, fsSecond, vsLow, vsFirst, vbCount, vbFirst;
    int rdB, rdBLate, hsLowB, hsFirstB;
    logic vb255, vb257;
    logic [3:0] col71, col17;

    nChecks = 0;
    nFail   = 0;
    cyc     = -1;

    applyStimulus(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] reset values, full-size instance");
    checkResetA("A reset");

    // ---------- full-size instance, first line ----------
    applyStimulus(1'b0, 1'b1);
    cyc = -1;
    tick();
    checkOutput("A c0 rd_en", fbA.rd_en, 1);
    checkOutput("A c0 rd_x", fbA.rd_x, 0);
    checkOutput("A c0 rd_y", fbA.rd_y, 0);
    checkOutput("A c0 frame_start", fsA, 0);
    tick();
    checkOutput("A c1 frame_start", fsA, 1);
    checkOutput("A c1 rd_en", fbA.rd_en, 0);
    checkOutput("A c1 hs", hsA, 1);
    checkOutput("A c1 vs", vsA, 1);
    checkOutput("A c1 vblank", vblankA, 0);
    tick();
    checkOutput("A c2 frame_start", fsA, 0);
    checkOutput("A c2 rd_en", fbA.rd_en, 1);
    checkOutput("A c2 rd_x", fbA.rd_x, 1);
    runTo(10);
    checkOutput("A c10 rd_x", fbA.rd_x, 5);
    runTo(11);
    checkOutput("A pix5 r", rA, 5);
    checkOutput("A pix5 g", gA, 5);
    checkOutput("A pix5 b", bA, 5);
    runTo(12);
    checkOutput("A pix5 held r", rA, 5);
    checkOutput("A c12 rd_x", fbA.rd_x, 6);
    runTo(13);
    checkOutput("A pix6 r", rA, 6);

    hsLow = 0; hsFirst = -1; rdCount = 0; grayBad = 0;
    col1277 = 4'h0; col1281 = 4'hA;
    while (cyc < 1599) begin
      tick();
      if (!hsA) begin
        hsLow++;
        if (hsFirst < 0) hsFirst = cyc;
      end
      if (fbA.rd_en) rdCount++;
      if (rA != gA || rA != bA) grayBad++;
      if (cyc == 1277) col1277 = rA;
      if (cyc == 1281) col1281 = rA;
    end
    checkOutput("A hs first low clk", hsFirst, 1313);
    checkOutput("A hs low clk count", hsLow, 192);
    checkOutput("A rd_en count pixels 7..639", rdCount, 633);
    checkOutput("A grayscale mismatches", grayBad, 0);
    checkOutput("A pix638 colour", col1277, 14);
    checkOutput("A pix640 colour", col1281, 0);

    runTo(1600);
    checkOutput("A line1 rd_en", fbA.rd_en, 1);
    checkOutput("A line1 rd_x", fbA.rd_x, 0);
    checkOutput("A line1 rd_y", fbA.rd_y, 1);
    runTo(1607);
    checkOutput("A line1 pix3 colour", rA, 3);

    // ---------- mid-line reset on full-size instance at (300,1) ----------
    runTo(2200);
    checkOutput("A pre-reset rd_x", fbA.rd_x, 300);
    checkOutput("A pre-reset rd_y", fbA.rd_y, 1);
    applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkResetA("A midline reset");
    applyStimulus(1'b0, 1'b1);
    cyc = -1;
    tick();
    checkOutput("A restart rd_en", fbA.rd_en, 1);
    checkOutput("A restart rd_x", fbA.rd_x, 0);
    checkOutput("A restart rd_y", fbA.rd_y, 0);
    tick();
    checkOutput("A restart frame_start", fsA, 1);

    // ---------- small instance, whole frames ----------
    $display("[TB] small raster instance");
    applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkResetB("B reset");
    applyStimulus(1'b1, 1'b0);
    cyc = -1;
    fsCount = 0; fsFirst = -1; fsSecond = -1;
    vsLow = 0; vsFirst = -1; vbCount = 0; vbFirst = -1;
    rdB = 0; rdBLate = 0; hsLowB = 0; hsFirstB = -1;
    vb255 = 1'b0; vb257 = 1'b1; col71 = 4'h0; col17 = 4'hA;
    while (cyc < 300) begin
      tick();
      if (fsB) begin
        fsCount++;
        if (fsFirst < 0) fsFirst = cyc;
        else if (fsSecond < 0) fsSecond = cyc;
      end
      if (cyc <= 255) begin
        if (!vsB) begin
          vsLow++;
          if (vsFirst < 0) vsFirst = cyc;
        end
        if (vblankB) begin
          vbCount++;
          if (vbFirst < 0) vbFirst = cyc;
        end
        if (!hsB) begin
          hsLowB++;
          if (hsFirstB < 0) hsFirstB = cyc;
        end
        if (fbB.rd_en) rdB++;
        if (fbB.rd_en && cyc >= 128) rdBLate++;
      end
      if (cyc == 17) col17 = rB;
      if (cyc == 71) col71 = rB;
      if (cyc == 255) vb255 = vblankB;
      if (cyc == 257) vb257 = vblankB;
    end
    checkOutput("B frame_start count", fsCount, 2);
    checkOutput("B frame_start first", fsFirst, 1);
    checkOutput("B frame_start second", fsSecond, 257);
    checkOutput("B vs low clk count", vsLow, 64);
    checkOutput("B vs first low", vsFirst, 161);
    checkOutput("B vblank clk count", vbCount, 127);
    checkOutput("B vblank first", vbFirst, 129);
    checkOutput("B hs low clk count", hsLowB, 48);
    checkOutput("B hs first low", hsFirstB, 21);
    checkOutput("B rd_en count", rdB, 32);
    checkOutput("B rd_en in vblank", rdBLate, 0);
    checkOutput("B vblank last line", vb255, 1);
    checkOutput("B vblank cleared", vb257, 0);
    checkOutput("B pix(3,2) colour", col71, 3);
    checkOutput("B pix(8,0) blank colour", col17, 0);

    // ---------- mid-frame reset on small instance at (11,5) ----------
    runTo(439);
    checkOutput("B pre-reset hs", hsB, 0);
    checkOutput("B pre-reset vs", vsB, 0);
    checkOutput("B pre-reset vblank", vblankB, 1);
    checkOutput("B held rd_x", fbB.rd_x, 7);
    checkOutput("B held rd_y", fbB.rd_y, 3);
    applyStimulus(1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkResetB("B midframe reset");
    applyStimulus(1'b1, 1'b0);
    cyc = -1;
    tick();
    checkOutput("B restart rd_en", fbB.rd_en, 1);
    checkOutput("B restart rd_x", fbB.rd_x, 0);
    checkOutput("B restart rd_y", fbB.rd_y, 0);
    tick();
    checkOutput("B restart frame_start", fsB, 1);
    checkOutput("B restart vblank", vblankB, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
